// File: rtl/axil_uart_regs.sv
// axil_uart_regs: AXI4-Lite register bank for the UART core.
// Buffers TX/RX bytes in FIFOs, holds the baud divisor and sticky error bits.
// Optional feature macro: AXIL_UART_IRQ_EN adds IRQ_EN/IRQ_STAT registers and
// the irq output; without it offsets 0x14/0x18 decode as unmapped.
//
// Handshake rule for every channel (AXI and byte streams): a transfer happens
// on the rising ACLK edge where VALID and READY are both high; a VALID source
// holds its payload stable until that edge, and READY never waits on VALID.
module axil_uart_regs #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RESET = 16'd87
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              uart_en,
  output logic [DIV_W-1:0]  baud_div
`ifdef AXIL_UART_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_BAUD     = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_TXDATA   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_RXDATA   = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(8'h10);
`ifdef AXIL_UART_IRQ_EN
  localparam logic [ADDR_W-1:0] A_IRQ_EN   = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] A_IRQ_STAT = ADDR_W'(8'h18);
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  // Replace only the strobed byte lanes of a 32-bit register image.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              aw_hs, w_hs, ar_hs, do_write;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_err;
  logic [31:0]       rd_data;
  logic              rd_err;

  logic              ctrl_en;
  logic              rx_ovr, tx_ovf;
  logic              tx_flush, rx_flush;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]     tx_wptr, tx_rptr;
  logic [CW-1:0]     tx_count;
  logic              tx_full, tx_empty, tx_push_req, tx_push, tx_pop, tx_ovf_set;

  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     rx_wptr, rx_rptr;
  logic [CW-1:0]     rx_count;
  logic              rx_full, rx_empty, rx_push, rx_pop, rx_ovr_set;

`ifdef AXIL_UART_IRQ_EN
  logic [2:0]        irq_en;
  logic [2:0]        irq_stat;
`endif

  // ---------------- write channel ----------------
  assign AWREADY = ARESETN & ((w_state == W_IDLE) | (w_state == W_HAVE_W));
  assign WREADY  = ARESETN & ((w_state == W_IDLE) | (w_state == W_HAVE_AW));
  assign BVALID  = (w_state == W_RESP);
  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;

  // Effective write transaction: captured half if already held, else live bus.
  assign wr_addr = (w_state == W_HAVE_AW) ? aw_addr_q : AWADDR;
  assign wr_data = (w_state == W_HAVE_W)  ? w_data_q  : WDATA;
  assign wr_strb = (w_state == W_HAVE_W)  ? w_strb_q  : WSTRB;

  // Write FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write FSM next state; do_write fires on the edge both halves are present.
  always_comb begin
    w_next   = w_state;
    do_write = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          do_write = 1'b1;
          w_next   = W_RESP;
        end else if (aw_hs) begin
          w_next = W_HAVE_AW;
        end else if (w_hs) begin
          w_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs) begin
        do_write = 1'b1;
        w_next   = W_RESP;
      end
      W_HAVE_W: if (aw_hs) begin
        do_write = 1'b1;
        w_next   = W_RESP;
      end
      W_RESP: if (BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Capture early-arriving address/data halves and the write response.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BRESP     <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_addr_q <= AWADDR;
      if (w_hs) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (do_write) BRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Write address decode: anything outside the map is an error.
  always_comb begin
    wr_err = 1'b0;
    case (wr_addr)
      A_CTRL, A_BAUD, A_TXDATA, A_RXDATA, A_STATUS: wr_err = 1'b0;
`ifdef AXIL_UART_IRQ_EN
      A_IRQ_EN, A_IRQ_STAT: wr_err = 1'b0;
`endif
      default: wr_err = 1'b1;
    endcase
  end

  assign tx_flush = do_write & (wr_addr == A_CTRL) & wr_strb[0] & wr_data[1];
  assign rx_flush = do_write & (wr_addr == A_CTRL) & wr_strb[0] & wr_data[2];

  // Control, baud divisor and sticky error registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ctrl_en  <= 1'b0;
      baud_div <= DIV_RESET;
      rx_ovr   <= 1'b0;
      tx_ovf   <= 1'b0;
    end else begin
      if (do_write && wr_addr == A_CTRL && wr_strb[0]) ctrl_en <= wr_data[0];
      if (do_write && wr_addr == A_BAUD)
        baud_div <= DIV_W'(merge_lanes(32'(baud_div), wr_data, wr_strb));
      if (do_write && wr_addr == A_STATUS && wr_strb[0]) begin
        if (wr_data[4]) rx_ovr <= 1'b0;
        if (wr_data[5]) tx_ovf <= 1'b0;
      end
      // A new error event in the same cycle as a clear keeps the bit set.
      if (rx_ovr_set) rx_ovr <= 1'b1;
      if (tx_ovf_set) tx_ovf <= 1'b1;
    end
  end

  assign uart_en = ctrl_en;

  // ---------------- TX FIFO ----------------
  assign tx_full     = (tx_count == CW'(FIFO_DEPTH));
  assign tx_empty    = (tx_count == '0);
  assign tx_valid    = ctrl_en & ~tx_empty;
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = do_write & (wr_addr == A_TXDATA) & wr_strb[0];
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop;
  assign tx_data     = tx_mem[tx_rptr];

  // TX storage write.
  always_ff @(posedge ACLK) begin
    if (tx_push && !tx_flush) tx_mem[tx_wptr] <= wr_data[DATA_W-1:0];
  end

  // TX pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge ACLK) begin
    if (!ARESETN || tx_flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  assign rx_full    = (rx_count == CW'(FIFO_DEPTH));
  assign rx_empty   = (rx_count == '0);
  assign rx_ready   = ctrl_en & ~rx_full;
  assign rx_push    = rx_valid & rx_ready;
  assign rx_ovr_set = rx_valid & ctrl_en & rx_full;
  assign rx_pop     = ar_hs & (ARADDR == A_RXDATA) & ~rx_empty;

  // RX storage write.
  always_ff @(posedge ACLK) begin
    if (rx_push && !rx_flush) rx_mem[rx_wptr] <= rx_data;
  end

  // RX pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge ACLK) begin
    if (!ARESETN || rx_flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // ---------------- interrupt ----------------
`ifdef AXIL_UART_IRQ_EN
  assign irq_stat = irq_en & {rx_ovr | tx_ovf, tx_empty, ~rx_empty};

  // IRQ enable register and registered interrupt line.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (do_write && wr_addr == A_IRQ_EN && wr_strb[0]) irq_en <= wr_data[2:0];
      irq <= |irq_stat;
    end
  end
`endif

  // ---------------- read channel ----------------
  assign ARREADY = ARESETN & (r_state == R_IDLE);
  assign RVALID  = (r_state == R_RESP);
  assign ar_hs   = ARVALID & ARREADY;

  // Read data mux for the live AR address.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (ARADDR)
      A_CTRL:   rd_data[0] = ctrl_en;
      A_BAUD:   rd_data = 32'(baud_div);
      A_TXDATA: rd_data = '0;
      A_RXDATA: if (!rx_empty) begin
        rd_data[31]         = 1'b1;
        rd_data[DATA_W-1:0] = rx_mem[rx_rptr];
      end
      A_STATUS: begin
        rd_data[0]     = tx_full;
        rd_data[1]     = tx_empty;
        rd_data[2]     = rx_full;
        rd_data[3]     = rx_empty;
        rd_data[4]     = rx_ovr;
        rd_data[5]     = tx_ovf;
        rd_data[15:8]  = 8'(tx_count);
        rd_data[23:16] = 8'(rx_count);
      end
`ifdef AXIL_UART_IRQ_EN
      A_IRQ_EN:   rd_data[2:0] = irq_en;
      A_IRQ_STAT: rd_data[2:0] = irq_stat;
`endif
      default: rd_err = 1'b1;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read FSM next state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Register read response at the AR handshake; held until RREADY.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      RDATA <= '0;
      RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      RDATA <= rd_data;
      RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axil_uart_regs.sv
// tb_axil_uart_regs: directed bench for axil_uart_regs with response queues.
module tb_axil_uart_regs;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  logic              ACLK, ARESETN;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID, AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WVALID, WREADY;
  logic [1:0]        BRESP;
  logic              BVALID, BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID, ARREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID, RREADY;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid, tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_ready;
  logic              uart_en;
  logic [DIV_W-1:0]  baud_div;
`ifdef AXIL_UART_IRQ_EN
  logic              irq;
`endif

  axil_uart_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .uart_en(uart_en), .baud_div(baud_div)
`ifdef AXIL_UART_IRQ_EN
    , .irq(irq)
`endif
  );

  // ---------------- clock/reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [7:0]  exp_tx_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (BVALID && BREADY) begin
        if (exp_b_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_bresp: got 0x%0h expected none", BRESP);
        end else check("bresp", 64'(BRESP), 64'(exp_b_q.pop_front()));
      end
      if (RVALID && RREADY) begin
        if (exp_r_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rdata: got 0x%0h expected none", RDATA);
        end else check("rresp_rdata", 64'({RRESP, RDATA}), 64'(exp_r_q.pop_front()));
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_tx: got 0x%0h expected none", tx_data);
        end else check("tx_data", 64'(tx_data), 64'(exp_tx_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead,
                           input logic [1:0] exp_resp);
    int k;
    exp_b_q.push_back(exp_resp);
    fork
      begin : w_ch
        int kw;
        kw = 0;
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        @(negedge ACLK);
        while (!WREADY && kw < 50) begin kw++; @(negedge ACLK); end
        if (!WREADY) timeout("wready");
        @(posedge ACLK); #1;
        WVALID = 1'b0;
      end
      begin : aw_ch
        int ka;
        ka = 0;
        repeat (w_lead) @(posedge ACLK);
        if (w_lead > 0) #1;
        AWADDR = addr; AWVALID = 1'b1;
        @(negedge ACLK);
        while (!AWREADY && ka < 50) begin ka++; @(negedge ACLK); end
        if (!AWREADY) timeout("awready");
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
      end
    join
    k = 0;
    while (!BVALID && k < 50) begin k++; @(negedge ACLK); end
    if (!BVALID) timeout("bvalid");
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    int k;
    k = 0;
    exp_r_q.push_back({exp_resp, exp_data});
    ARADDR = addr; ARVALID = 1'b1;
    @(negedge ACLK);
    while (!ARREADY && k < 50) begin k++; @(negedge ACLK); end
    if (!ARREADY) timeout("arready");
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    check("rvalid_latency", 64'(RVALID), 64'(1));
    @(posedge ACLK); #1;
  endtask

  task automatic rx_inject(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge ACLK); #1;
    rx_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int seen;
    ARESETN = 1'b0; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0;
    WVALID = 1'b0; BREADY = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 64'(AWREADY), 64'(0));
    check("rst_wready",  64'(WREADY),  64'(0));
    check("rst_arready", 64'(ARREADY), 64'(0));
    check("rst_bvalid",  64'(BVALID),  64'(0));
    check("rst_rvalid",  64'(RVALID),  64'(0));
    check("rst_bresp",   64'(BRESP),   64'(0));
    check("rst_rresp",   64'(RRESP),   64'(0));
    check("rst_rdata",   64'(RDATA),   64'(0));
    check("rst_uart_en", 64'(uart_en), 64'(0));
    check("rst_baud",    64'(baud_div), 64'h57);
    check("rst_tx_valid", 64'(tx_valid), 64'(0));
    check("rst_rx_ready", 64'(rx_ready), 64'(0));
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Baud divisor and byte-lane strobes.
    axi_read(8'h04, 32'h0000_0057, 2'b00);
    axi_write(8'h04, 32'h1234_ABCD, 4'b0001, 3, 2'b00);
    axi_read(8'h04, 32'h0000_00CD, 2'b00);
    axi_write(8'h04, 32'hFFFF_1100, 4'b0010, 0, 2'b00);
    axi_write(8'h04, 32'h00AA_0000, 4'b0100, 0, 2'b00);
    axi_read(8'h04, 32'h0000_11CD, 2'b00);
    @(negedge ACLK);
    check("baud_port", 64'(baud_div), 64'h11CD);
    @(posedge ACLK); #1;
    axi_read(8'h10, 32'h0000_000A, 2'b00);

    // TX fill past full with the core stalled, then drain.
    axi_write(8'h00, 32'h1, 4'b0001, 0, 2'b00);
    @(negedge ACLK);
    check("uart_en", 64'(uart_en), 64'(1));
    @(posedge ACLK); #1;
    for (int i = 1; i <= 16; i++) exp_tx_q.push_back(8'(i));
    for (int i = 1; i <= 17; i++) axi_write(8'h08, 32'(i), 4'b0001, 0, 2'b00);
    axi_read(8'h10, 32'h0000_1029, 2'b00);
    tx_ready = 1'b1;
    k = 0;
    while (exp_tx_q.size() != 0 && k < 100) begin k++; @(posedge ACLK); end
    if (exp_tx_q.size() != 0) timeout("tx_drain");
    #1;
    axi_read(8'h10, 32'h0000_002A, 2'b00);
    axi_write(8'h10, 32'h0000_0020, 4'b0001, 0, 2'b00);
    axi_read(8'h10, 32'h0000_000A, 2'b00);

    // Single RX byte, then an empty read.
    @(negedge ACLK);
    check("rx_ready_en", 64'(rx_ready), 64'(1));
    @(posedge ACLK); #1;
    rx_inject(8'h41);
    axi_read(8'h0C, 32'h8000_0041, 2'b00);
    axi_read(8'h0C, 32'h0000_0000, 2'b00);
    axi_read(8'h10, 32'h0000_000A, 2'b00);

    // RX fill, overrun, W1C clear, pop, flush.
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h10 + i); rx_valid = 1'b1;
      @(posedge ACLK); #1;
    end
    rx_data = 8'hEE;
    @(negedge ACLK);
    check("rx_ready_full", 64'(rx_ready), 64'(0));
    @(posedge ACLK); #1;
    rx_valid = 1'b0;
    axi_read(8'h10, 32'h0010_0016, 2'b00);
    axi_write(8'h10, 32'h0000_0010, 4'b0001, 0, 2'b00);
    axi_read(8'h10, 32'h0010_0006, 2'b00);
    axi_read(8'h0C, 32'h8000_0010, 2'b00);
    axi_read(8'h10, 32'h000F_0002, 2'b00);
    axi_write(8'h00, 32'h0000_0005, 4'b0001, 0, 2'b00);
    axi_read(8'h00, 32'h0000_0001, 2'b00);
    axi_read(8'h10, 32'h0000_000A, 2'b00);

    // Unmapped and write-only offsets.
    axi_read(8'h20, 32'h0000_0000, 2'b10);
    axi_write(8'h20, 32'hFFFF_FFFF, 4'b1111, 0, 2'b10);
    axi_read(8'h1C, 32'h0000_0000, 2'b10);
    axi_read(8'h08, 32'h0000_0000, 2'b00);

    // Reset while a write response is pending.
    BREADY = 1'b0;
    AWADDR = 8'h04; WDATA = 32'h0000_0099; WSTRB = 4'b0001;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check("bvalid_pending", 64'(BVALID), 64'(1));
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check("bvalid_after_rst", 64'(BVALID), 64'(0));
    @(posedge ACLK); #1;
    ARESETN = 1'b1; BREADY = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge ACLK);
      if (BVALID) seen++;
    end
    check("late_bresp", 64'(seen), 64'(0));
    @(posedge ACLK); #1;
    axi_read(8'h00, 32'h0000_0000, 2'b00);
    axi_read(8'h04, 32'h0000_0057, 2'b00);

    repeat (3) @(posedge ACLK);
    check("b_q_empty",  64'(exp_b_q.size()),  64'(0));
    check("r_q_empty",  64'(exp_r_q.size()),  64'(0));
    check("tx_q_empty", 64'(exp_tx_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    n_checks++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
